// File: rtl/sink_serializer.sv
// -----------------------------------------------------------------------------
// sink_serializer
//
// Takes packets from network_sink through a valid/ready handshake and queues
// up to DEPTH of them in a small FIFO. It sends each packet to a byte-oriented
// host transmitter as NB = ceil(PKT_WIDTH/BYTE_WIDTH) words. Each word is
// BYTE_WIDTH bits wide. The most significant word goes first, and the packet
// is zero-extended on the MSB side.
//
// Build option:
//   SERIALIZER_SYNC_EN - when this macro is defined, a header word (SYNC_WORD)
//                        is sent before every packet.
//
// Ports:
//   clk         rising-edge clock for all logic
//   rst         synchronous active-high reset; clears the FIFO and any packet
//               that is part-way through serialization
//   pkt_valid   the sink presents a packet
//   pkt_ready   the FIFO has room; driven from count only and held low during rst
//   pkt         packet data (PKT_WIDTH bits)
//   byte_valid  byte_out holds a valid word
//   byte_ready  the transmitter accepts the current word
//   byte_out    the current word (BYTE_WIDTH bits)
//   count       packets waiting in the FIFO, not counting the one being sent
//
// DEPTH must be a power of two and at least 2. The pointers rely on natural
// wrap-around.
// -----------------------------------------------------------------------------
module sink_serializer #(
    parameter int PKT_WIDTH  = 16,
    parameter int BYTE_WIDTH = 8,
    parameter int DEPTH      = 4,
    parameter     SYNC_WORD  = 8'hA5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pkt_valid,
    output logic                       pkt_ready,
    input  logic [PKT_WIDTH-1:0]       pkt,
    output logic                       byte_valid,
    input  logic                       byte_ready,
    output logic [BYTE_WIDTH-1:0]      byte_out,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int NB   = (PKT_WIDTH + BYTE_WIDTH - 1) / BYTE_WIDTH;
    localparam int SR_W = NB * BYTE_WIDTH;
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int PW   = $clog2(DEPTH);
    localparam int IW   = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

`ifdef SERIALIZER_SYNC_EN
    typedef enum logic [1:0] {IDLE, HDR, SEND} state_t;
    // Every packet begins with the header word.
    localparam state_t PKT_START = HDR;
    localparam logic [BYTE_WIDTH-1:0] SYNC_BYTE = BYTE_WIDTH'(SYNC_WORD);
`else
    typedef enum logic [0:0] {IDLE, SEND} state_t;
    localparam state_t PKT_START = SEND;
`endif

    state_t              state_reg, state_next;
    logic [IW-1:0]       idx_reg, idx_next;
    logic [SR_W-1:0]     word_reg;
    logic [CW-1:0]       count_reg, count_next;
    logic [PW-1:0]       wr_ptr_reg, rd_ptr_reg;
    logic [PKT_WIDTH-1:0] mem [DEPTH];
    logic                push, load;
    logic [BYTE_WIDTH-1:0] words [NB];

    // The packet buffer viewed as an array of words, with word 0 being the MSB
    // word.
    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_words
            assign words[gi] = word_reg[(NB - 1 - gi) * BYTE_WIDTH +: BYTE_WIDTH];
        end
    endgenerate

    // When full, no push is accepted, even if a pop happens in the same
    // cycle. This keeps pkt_ready independent of the output side.
    assign pkt_ready = !rst && (count_reg < CW'(DEPTH));
    assign push      = pkt_valid && pkt_ready;
    assign count     = count_reg;

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        load       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (count_reg != '0) begin
                    load       = 1'b1;
                    idx_next   = '0;
                    state_next = PKT_START;
                end
            end
`ifdef SERIALIZER_SYNC_EN
            HDR: begin
                if (byte_ready) begin
                    state_next = SEND;
                end
            end
`endif
            SEND: begin
                if (byte_ready) begin
                    if (idx_reg == LAST_IDX) begin
                        idx_next = '0;
                        // Reload straight from the FIFO head so there is no
                        // idle cycle between packets.
                        if (count_reg != '0) begin
                            load       = 1'b1;
                            state_next = PKT_START;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        idx_next = idx_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A pop always goes with a load into the packet buffer.
    always_comb begin
        count_next = count_reg;
        case ({push, load})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        byte_valid = (state_reg != IDLE);
        byte_out   = '0;
        case (state_reg)
            SEND:    byte_out = words[idx_reg];
`ifdef SERIALIZER_SYNC_EN
            HDR:     byte_out = SYNC_BYTE;
`endif
            default: byte_out = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            idx_reg    <= '0;
            word_reg   <= '0;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (load) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                word_reg   <= SR_W'(mem[rd_ptr_reg]);
            end
        end
    end

    // FIFO storage. The packet buffer is the registered copy of the head
    // entry, so the array itself is read without a separate output register.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= pkt;
        end
    end

endmodule

// File: tb/tb_sink_serializer.sv
// -----------------------------------------------------------------------------
// tb_sink_serializer
//
// Self-checking bench for sink_serializer. It uses three instances:
//   u_dut16  PKT_WIDTH=16 - the main cycle-by-cycle vector table
//   u_dut12  PKT_WIDTH=12 - zero-extension and first-word latency
//   u_dut8   PKT_WIDTH=8  - NB==1, back-to-back whole-packet words
// The expected values change when SERIALIZER_SYNC_EN is defined.
// -----------------------------------------------------------------------------
module tb_sink_serializer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        pv16, br16, prdy16, bv16;
    logic [15:0] pkt16;
    logic [7:0]  bo16;
    logic [2:0]  cnt16;

    logic        pv12, br12, prdy12, bv12;
    logic [11:0] pkt12;
    logic [7:0]  bo12;
    logic [2:0]  cnt12;

    logic        pv8, br8, prdy8, bv8;
    logic [7:0]  pkt8;
    logic [7:0]  bo8;
    logic [2:0]  cnt8;

    sink_serializer #(.PKT_WIDTH(16), .BYTE_WIDTH(8), .DEPTH(4), .SYNC_WORD(8'hA5)) u_dut16 (
        .clk(clk), .rst(rst), .pkt_valid(pv16), .pkt_ready(prdy16), .pkt(pkt16),
        .byte_valid(bv16), .byte_ready(br16), .byte_out(bo16), .count(cnt16)
    );

    sink_serializer #(.PKT_WIDTH(12), .BYTE_WIDTH(8), .DEPTH(4), .SYNC_WORD(8'hA5)) u_dut12 (
        .clk(clk), .rst(rst), .pkt_valid(pv12), .pkt_ready(prdy12), .pkt(pkt12),
        .byte_valid(bv12), .byte_ready(br12), .byte_out(bo12), .count(cnt12)
    );

    sink_serializer #(.PKT_WIDTH(8), .BYTE_WIDTH(8), .DEPTH(4), .SYNC_WORD(8'hA5)) u_dut8 (
        .clk(clk), .rst(rst), .pkt_valid(pv8), .pkt_ready(prdy8), .pkt(pkt8),
        .byte_valid(bv8), .byte_ready(br8), .byte_out(bo8), .count(cnt8)
    );

    typedef struct {
        logic        rst;
        logic        pv;
        logic [15:0] pkt;
        logic        br;
        logic        ev;
        logic [7:0]  eb;
        logic [2:0]  ec;
        logic        er;
    } vec_t;

    vec_t vecs[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void add(input logic r, input logic pv, input logic [15:0] p,
                                input logic br, input logic ev, input logic [7:0] eb,
                                input logic [2:0] ec, input logic er);
        vec_t v;
        v.rst = r; v.pv = pv; v.pkt = p; v.br = br;
        v.ev = ev; v.eb = eb; v.ec = ec; v.er = er;
        vecs.push_back(v);
    endfunction

    // One row per cycle. The inputs apply during that cycle. The expected
    // values are byte_valid, byte_out, count and pkt_ready in the same cycle.
    function automatic void fill_table();
`ifdef SERIALIZER_SYNC_EN
        // Two back-to-back packets, each with a header word.
        add(0, 1, 16'h1234, 1, 0, 8'h00, 0, 1);
        add(0, 1, 16'h5678, 1, 0, 8'h00, 1, 1);
        add(0, 0, 16'h0000, 1, 1, 8'hA5, 1, 1);
        add(0, 0, 16'h0000, 1, 1, 8'h12, 1, 1);
        add(0, 0, 16'h0000, 1, 1, 8'h34, 1, 1);
        add(0, 0, 16'h0000, 1, 1, 8'hA5, 0, 1);
        add(0, 0, 16'h0000, 1, 1, 8'h56, 0, 1);
        add(0, 0, 16'h0000, 1, 1, 8'h78, 0, 1);
        // A stall on the header word.
        add(0, 1, 16'h9ABC, 0, 0, 8'h00, 0, 1);
        add(0, 0, 16'h0000, 0, 0, 8'h00, 1, 1);
        add(0, 0, 16'h0000, 0, 1, 8'hA5, 0, 1);
        add(0, 0, 16'h0000, 1, 1, 8'hA5, 0, 1);
        add(0, 0, 16'h0000, 1, 1, 8'h9A, 0, 1);
        add(0, 0, 16'h0000, 1, 1, 8'hBC, 0, 1);
        add(0, 0, 16'h0000, 1, 0, 8'h00, 0, 1);
        // A reset during the header discards the packet.
        add(0, 1, 16'hCAFE, 1, 0, 8'h00, 0, 1);
        add(0, 0, 16'h0000, 1, 0, 8'h00, 1, 1);
        add(1, 0, 16'h0000, 1, 1, 8'hA5, 0, 0);
        add(0, 0, 16'h0000, 1, 0, 8'h00, 0, 1);
        add(0, 0, 16'h0000, 1, 0, 8'h00, 0, 1);
`else
        // Fill while stalled. 1111 sits in the buffer and 2222..5555 fill the FIFO.
        add(0, 1, 16'h1111, 0, 0, 8'h00, 0, 1);
        add(0, 1, 16'h2222, 0, 0, 8'h00, 1, 1);
        add(0, 1, 16'h3333, 0, 1, 8'h11, 1, 1);
        add(0, 1, 16'h4444, 0, 1, 8'h11, 2, 1);
        add(0, 1, 16'h5555, 0, 1, 8'h11, 3, 1);
        add(0, 1, 16'h6666, 0, 1, 8'h11, 4, 0);
        // Release. On the last word of 1111 the FIFO is full and a pop happens,
        // so there is no push. 6666 is pushed in the following cycle.
        add(0, 1, 16'h6666, 1, 1, 8'h11, 4, 0);
        add(0, 1, 16'h6666, 1, 1, 8'h11, 4, 0);
        add(0, 1, 16'h6666, 1, 1, 8'h22, 3, 1);
        add(0, 0, 16'h0000, 1, 1, 8'h22, 4, 0);
        add(0, 0, 16'h0000, 1, 1, 8'h33, 3, 1);
        add(0, 0, 16'h0000, 1, 1, 8'h33, 3, 1);
        add(0, 0, 16'h0000, 1, 1, 8'h44, 2, 1);
        add(0, 0, 16'h0000, 1, 1, 8'h44, 2, 1);
        add(0, 0, 16'h0000, 1, 1, 8'h55, 1, 1);
        add(0, 0, 16'h0000, 1, 1, 8'h55, 1, 1);
        add(0, 0, 16'h0000, 1, 1, 8'h66, 0, 1);
        add(0, 0, 16'h0000, 1, 1, 8'h66, 0, 1);
        add(0, 0, 16'h0000, 1, 0, 8'h00, 0, 1);
        // Backpressure on BEEF.
        add(0, 1, 16'hBEEF, 0, 0, 8'h00, 0, 1);
        add(0, 0, 16'h0000, 1, 0, 8'h00, 1, 1);
        add(0, 0, 16'h0000, 0, 1, 8'hBE, 0, 1);
        add(0, 0, 16'h0000, 0, 1, 8'hBE, 0, 1);
        add(0, 0, 16'h0000, 1, 1, 8'hBE, 0, 1);
        add(0, 0, 16'h0000, 1, 1, 8'hEF, 0, 1);
        add(0, 0, 16'h0000, 1, 0, 8'h00, 0, 1);
        // Reset after the first word of CAFE, with D00D and F00D queued.
        add(0, 1, 16'hCAFE, 1, 0, 8'h00, 0, 1);
        add(0, 1, 16'hD00D, 1, 0, 8'h00, 1, 1);
        add(0, 1, 16'hF00D, 1, 1, 8'hCA, 1, 1);
        add(1, 0, 16'h0000, 1, 1, 8'hFE, 2, 0);
        add(0, 0, 16'h0000, 1, 0, 8'h00, 0, 1);
        add(0, 0, 16'h0000, 1, 0, 8'h00, 0, 1);
        add(0, 0, 16'h0000, 1, 0, 8'h00, 0, 1);
        // Recovery with a fresh push.
        add(0, 1, 16'h1234, 1, 0, 8'h00, 0, 1);
        add(0, 0, 16'h0000, 1, 0, 8'h00, 1, 1);
        add(0, 0, 16'h0000, 1, 1, 8'h12, 0, 1);
        add(0, 0, 16'h0000, 1, 1, 8'h34, 0, 1);
        add(0, 0, 16'h0000, 1, 0, 8'h00, 0, 1);
`endif
    endfunction

    logic [7:0] exp_q[$];

    initial begin
        rst = 1'b1;
        pv16 = 0; br16 = 0; pkt16 = '0;
        pv12 = 0; br12 = 0; pkt12 = '0;
        pv8  = 0; br8  = 0; pkt8  = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset pkt_ready", prdy16, 1'b0);
        chk("reset count", cnt16, 3'd0);
        chk("reset byte_valid", bv16, 1'b0);
        chk("reset byte_out", bo16, 8'h00);
        rst = 1'b0;
        #1;
        chk("post-reset pkt_ready", prdy16, 1'b1);
        step();

        // 12-bit packet ABC: zero-extended to 0ABC; the first word appears at N+2.
        pv12 = 1; pkt12 = 12'hABC; br12 = 1;
        #1;
        chk("w12 N pkt_ready", prdy12, 1'b1);
        chk("w12 N byte_valid", bv12, 1'b0);
        step();
        pv12 = 0;
        #1;
        chk("w12 N+1 count", cnt12, 3'd1);
        chk("w12 N+1 byte_valid", bv12, 1'b0);
        step();
`ifdef SERIALIZER_SYNC_EN
        exp_q = '{8'hA5, 8'h0A, 8'hBC};
`else
        exp_q = '{8'h0A, 8'hBC};
`endif
        foreach (exp_q[k]) begin
            chk($sformatf("w12 word%0d valid", k), bv12, 1'b1);
            chk($sformatf("w12 word%0d byte", k), bo12, exp_q[k]);
            step();
        end
        chk("w12 end byte_valid", bv12, 1'b0);
        chk("w12 end count", cnt12, 3'd0);

        // NB==1: two back-to-back packets, with one whole packet per word.
        pv8 = 1; pkt8 = 8'h3C; br8 = 1;
        step();
        pkt8 = 8'hC3;
        #1;
        chk("w8 N+1 count", cnt8, 3'd1);
        step();
        pv8 = 0;
`ifdef SERIALIZER_SYNC_EN
        exp_q = '{8'hA5, 8'h3C, 8'hA5, 8'hC3};
`else
        exp_q = '{8'h3C, 8'hC3};
`endif
        foreach (exp_q[k]) begin
            #1;
            chk($sformatf("w8 word%0d valid", k), bv8, 1'b1);
            chk($sformatf("w8 word%0d byte", k), bo8, exp_q[k]);
            step();
        end
        chk("w8 end byte_valid", bv8, 1'b0);
        chk("w8 end count", cnt8, 3'd0);

        // Main vector table on the 16-bit instance.
        fill_table();
        foreach (vecs[i]) begin
            rst   = vecs[i].rst;
            pv16  = vecs[i].pv;
            pkt16 = vecs[i].pkt;
            br16  = vecs[i].br;
            #1;
            chk($sformatf("row%0d byte_valid", i), bv16, vecs[i].ev);
            chk($sformatf("row%0d byte_out", i), bo16, vecs[i].eb);
            chk($sformatf("row%0d count", i), cnt16, vecs[i].ec);
            chk($sformatf("row%0d pkt_ready", i), prdy16, vecs[i].er);
            step();
        end
        rst = 0; pv16 = 0; br16 = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
